// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU execute block and for the ALU controller
// that drives its Operation input. Both sides import this package, so the
// operation encoding is defined in exactly one place.
//
// Contents:
//   OP_*             4-bit Operation codes.
//   alu_state_e      execute-block FSM states. ST_SHIFT only exists when
//                    ALU_ITER_SHIFT_EN is defined (iterative shifter build).
//   shift_kind_e     which of the three shifts the shifter should perform.
//   is_shift_op()    true for SRL/SLL/SRA.
//   shift_kind_of()  maps an Operation code onto a shift_kind_e.
//
// Configuration macro: ALU_ITER_SHIFT_EN
// ---------------------------------------------------------------------------
package alu_pkg;

  // Operation encoding. Codes 4'b1101..4'b1111 are reserved and produce a
  // zero result with no branch.
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_SRA = 4'b0111;
  localparam logic [3:0] OP_BEQ = 4'b1000;
  localparam logic [3:0] OP_BLT = 4'b1001;
  localparam logic [3:0] OP_BGE = 4'b1010;
  localparam logic [3:0] OP_BNE = 4'b1011;
  localparam logic [3:0] OP_SLT = 4'b1100;

  // The SHIFT state is only meaningful with the iterative shifter; the
  // barrel build has no multi-cycle operations at all.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
`ifdef ALU_ITER_SHIFT_EN
    ST_SHIFT = 2'd1,
`endif
    ST_DONE  = 2'd2
  } alu_state_e;

  typedef enum logic [1:0] {
    SH_SRL = 2'd0,
    SH_SLL = 2'd1,
    SH_SRA = 2'd2
  } shift_kind_e;

  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  endfunction

  // Non-shift codes fall through to SRL; the shifter output is simply not
  // selected for them.
  function automatic shift_kind_e shift_kind_of(input logic [3:0] op);
    case (op)
      OP_SLL:  return SH_SLL;
      OP_SRA:  return SH_SRA;
      default: return SH_SRL;
    endcase
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// ---------------------------------------------------------------------------
// alu_shifter
// Shift datapath of the ALU execute block.
//
// With ALU_ITER_SHIFT_EN defined the shifter is iterative: a load captures
// the operand, the shift kind and the 5-bit shift amount, then every step
// moves the value by one bit position and decrements the counter.
// Without the macro it is a purely combinational barrel shifter.
//
// Ports (iterative build only):
//   clk, reset  clock and asynchronous active-high reset
//   load        capture operand/kind/shamt this cycle
//   step        perform one single-bit shift this cycle
//   last_step   the current step is the final one (counter == 1)
// Ports (both builds):
//   kind        SRL / SLL / SRA
//   operand     value to shift (captured on load in the iterative build)
//   shamt       shift amount, 0..31
//   result      iterative: value after the current step
//               barrel:    fully shifted operand
//
// Configuration macro: ALU_ITER_SHIFT_EN
// ---------------------------------------------------------------------------
module alu_shifter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
`ifdef ALU_ITER_SHIFT_EN
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  step,
  output logic                  last_step,
`endif
  input  shift_kind_e           kind,
  input  logic [DATA_WIDTH-1:0] operand,
  input  logic [4:0]            shamt,
  output logic [DATA_WIDTH-1:0] result
);

`ifdef ALU_ITER_SHIFT_EN

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [4:0]            count_q, count_d;
  shift_kind_e           kind_q,  kind_d;
  logic [DATA_WIDTH-1:0] step_val;

  // One single-bit shift of the working value. SRA keeps re-using the
  // current MSB, which is still the original sign bit because an arithmetic
  // right shift never changes it.
  always_comb begin
    step_val = shift_q;
    case (kind_q)
      SH_SRL:  step_val = {1'b0, shift_q[DATA_WIDTH-1:1]};
      SH_SLL:  step_val = {shift_q[DATA_WIDTH-2:0], 1'b0};
      SH_SRA:  step_val = {shift_q[DATA_WIDTH-1], shift_q[DATA_WIDTH-1:1]};
      default: step_val = shift_q;
    endcase
  end

  // Load has priority over step so a new operation always starts cleanly.
  // The counter never wraps below zero even if step is held too long.
  always_comb begin
    shift_d = shift_q;
    count_d = count_q;
    kind_d  = kind_q;
    if (load) begin
      shift_d = operand;
      count_d = shamt;
      kind_d  = kind;
    end else if (step && (count_q != 5'd0)) begin
      shift_d = step_val;
      count_d = count_q - 5'd1;
    end
  end

  // Working registers; reset discards any partially shifted value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= 5'd0;
      kind_q  <= SH_SRL;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      kind_q  <= kind_d;
    end
  end

  // The owner samples result on the step where last_step is high, so it
  // receives the value after the final shift without an extra cycle.
  assign result    = step_val;
  assign last_step = (count_q == 5'd1);

`else

  // Single-cycle barrel shifter; SRA fills with the operand's sign bit.
  always_comb begin
    result = operand;
    case (kind)
      SH_SRL:  result = operand >> shamt;
      SH_SLL:  result = operand << shamt;
      SH_SRA:  result = $signed(operand) >>> shamt;
      default: result = operand;
    endcase
  end

`endif

endmodule

// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec
// Execute-stage ALU with valid/ready handshakes on both sides and a
// registered result. Logic, add/sub, compare and branch conditions are
// computed here; shifts are delegated to alu_shifter.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   Operation/SrcA/SrcB valid this cycle
//   in_ready   an operation is accepted this cycle if in_valid is high
//   Operation  4-bit operation code (alu_pkg::OP_*)
//   SrcA       first operand
//   SrcB       second operand; bits [4:0] are the shift amount for shifts
//   out_valid  ALUResult/BrTaken hold a completed result
//   out_ready  consumer takes the result this cycle
//   ALUResult  registered result (0 for branch and reserved ops)
//   BrTaken    registered branch condition (0 for non-branch ops)
//
// Configuration macro: ALU_ITER_SHIFT_EN
//   defined   - shifts by a non-zero amount take one cycle per bit in the
//               SHIFT state, giving shamt+1 cycles of latency
//   undefined - shifts use a barrel shifter, every op has 1-cycle latency
// ---------------------------------------------------------------------------
module alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  BrTaken
);

  alu_state_e            state_q,     state_d;
  logic [DATA_WIDTH-1:0] result_q,    result_d;
  logic                  br_taken_q,  br_taken_d;

  logic                  accept;
  logic                  ops_equal;
  logic                  signed_lt;
  logic [DATA_WIDTH-1:0] alu_res_c;
  logic                  br_c;
  logic [DATA_WIDTH-1:0] shift_res;

`ifdef ALU_ITER_SHIFT_EN
  logic                  shift_load;
  logic                  shift_step;
  logic                  shift_last;
`endif

  // A finished result may be replaced in the same cycle it is consumed,
  // which is what allows back-to-back single-cycle operations.
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign ALUResult = result_q;
  assign BrTaken   = br_taken_q;

  assign ops_equal = (SrcA == SrcB);
  assign signed_lt = ($signed(SrcA) < $signed(SrcB));

  alu_shifter #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shifter (
`ifdef ALU_ITER_SHIFT_EN
    .clk        (clk),
    .reset      (reset),
    .load       (shift_load),
    .step       (shift_step),
    .last_step  (shift_last),
`endif
    .kind       (shift_kind_of(Operation)),
    .operand    (SrcA),
    .shamt      (SrcB[4:0]),
    .result     (shift_res)
  );

  // Single-cycle result for the operation currently on the inputs. With the
  // iterative shifter this path only completes a shift when the amount is
  // zero, in which case the result is just SrcA.
  always_comb begin
    alu_res_c = '0;
    br_c      = 1'b0;
    case (Operation)
      OP_AND: alu_res_c = SrcA & SrcB;
      OP_OR:  alu_res_c = SrcA | SrcB;
      OP_ADD: alu_res_c = SrcA + SrcB;
      OP_XOR: alu_res_c = SrcA ^ SrcB;
      OP_SUB: alu_res_c = SrcA - SrcB;
      OP_SRL, OP_SLL, OP_SRA: begin
`ifdef ALU_ITER_SHIFT_EN
        alu_res_c = SrcA;
`else
        alu_res_c = shift_res;
`endif
      end
      OP_BEQ: br_c = ops_equal;
      OP_BLT: br_c = signed_lt;
      OP_BGE: br_c = !signed_lt;
      OP_BNE: br_c = !ops_equal;
      OP_SLT: alu_res_c = {{(DATA_WIDTH-1){1'b0}}, signed_lt};
      default: begin
        alu_res_c = '0;
        br_c      = 1'b0;
      end
    endcase
  end

  // Next-state and result-register logic. IDLE and DONE share the accept
  // path; DONE additionally falls back to IDLE once its result is consumed
  // and no new operation is waiting. Operands are only looked at on an
  // accept, so they are ignored in every other cycle.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    br_taken_d = br_taken_q;
`ifdef ALU_ITER_SHIFT_EN
    shift_load = 1'b0;
    shift_step = 1'b0;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
`ifdef ALU_ITER_SHIFT_EN
          if (is_shift_op(Operation) && (SrcB[4:0] != 5'd0)) begin
            state_d    = ST_SHIFT;
            shift_load = 1'b1;
            br_taken_d = 1'b0;
          end else
`endif
          begin
            state_d    = ST_DONE;
            result_d   = alu_res_c;
            br_taken_d = br_c;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
`ifdef ALU_ITER_SHIFT_EN
      // The last step's output is captured directly, so DONE is reached on
      // the same edge that takes the counter to zero.
      ST_SHIFT: begin
        shift_step = 1'b1;
        if (shift_last) begin
          state_d  = ST_DONE;
          result_d = shift_res;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers. Reset is asynchronous so the block drops
  // out of a long shift immediately, discarding the partial result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      br_taken_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      br_taken_q <= br_taken_d;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_exec
// Self-checking bench for alu_exec (DATA_WIDTH = 32). A table of operations
// with hand-derived results is driven through the input handshake; every
// accepted operation pushes its expected result and latency onto a
// scoreboard queue that a monitor pops when the DUT presents the result.
// Hand-written sequences cover backpressure, the shift-state in_ready
// behaviour and asynchronous reset in the middle of an operation.
// Works with and without ALU_ITER_SHIFT_EN.
// ---------------------------------------------------------------------------
module tb_alu_exec;

  localparam logic [3:0] T_AND = 4'b0000;
  localparam logic [3:0] T_OR  = 4'b0001;
  localparam logic [3:0] T_ADD = 4'b0010;
  localparam logic [3:0] T_XOR = 4'b0011;
  localparam logic [3:0] T_SUB = 4'b0100;
  localparam logic [3:0] T_SRL = 4'b0101;
  localparam logic [3:0] T_SLL = 4'b0110;
  localparam logic [3:0] T_SRA = 4'b0111;
  localparam logic [3:0] T_BEQ = 4'b1000;
  localparam logic [3:0] T_BLT = 4'b1001;
  localparam logic [3:0] T_BGE = 4'b1010;
  localparam logic [3:0] T_BNE = 4'b1011;
  localparam logic [3:0] T_SLT = 4'b1100;

`ifdef ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        br;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        br;
    int          lat;
    int          accept_cycle;
  } sb_entry_t;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        BrTaken;

  int          compared;
  int          mismatched;
  int          cycle_cnt;
  bit          latency_seen;
  sb_entry_t   sb_q[$];
  sb_entry_t   mon_e;
  vec_t        vecs[20];

  alu_exec #(
    .DATA_WIDTH (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .BrTaken   (BrTaken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt++;

  // Cycles from accept to out_valid: shifts by a non-zero amount take one
  // cycle per bit plus one with the iterative shifter; everything else 1.
  function automatic int expLatency(input logic [3:0] op, input logic [31:0] b);
    if (ITER && ((op == T_SRL) || (op == T_SLL) || (op == T_SRA)) && (b[4:0] != 5'd0))
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one operation from posedge+1 and hold it until accepted; on the
  // accepting edge the expectation is pushed onto the scoreboard. Returns
  // at posedge+1 with in_valid still high so calls can run back-to-back.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] res,
                               input logic br);
    sb_entry_t e;
    int        waited;
    Operation = op;
    SrcA      = a;
    SrcB      = b;
    in_valid  = 1'b1;
    waited    = 0;
    @(negedge clk);
    while (!in_ready && (waited < 100)) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: in_ready stayed 0 for op %b", op);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.res          = res;
    e.br           = br;
    e.lat          = expLatency(op, b);
    e.accept_cycle = cycle_cnt;
    sb_q.push_back(e);
  endtask

  // Release the inputs and let every outstanding result drain out.
  task automatic drain();
    int waited;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waited    = 0;
    while ((sb_q.size() != 0) && (waited < 200)) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (sb_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d results still pending", sb_q.size());
      sb_q.delete();
    end
  endtask

  // Output monitor: while out_valid is high the held result must match the
  // oldest expectation; latency is checked once per result and the entry
  // is retired when the consumer takes it.
  always @(negedge clk) begin
    if (reset) begin
      latency_seen = 1'b0;
    end else if (out_valid) begin
      if (sb_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_output: got 0x%08h, expected no result", ALUResult);
      end else begin
        mon_e = sb_q[0];
        if (!latency_seen) begin
          checkOutput("latency", 32'(cycle_cnt - mon_e.accept_cycle + 1), 32'(mon_e.lat));
          latency_seen = 1'b1;
        end
        checkOutput("ALUResult", ALUResult, mon_e.res);
        checkOutput("BrTaken", 32'(BrTaken), 32'(mon_e.br));
        if (out_ready) begin
          void'(sb_q.pop_front());
          latency_seen = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    compared     = 0;
    mismatched   = 0;
    cycle_cnt    = 0;
    latency_seen = 1'b0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    Operation    = 4'b0000;
    SrcA         = '0;
    SrcB         = '0;

    vecs[0]  = '{T_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    vecs[1]  = '{T_BLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    vecs[2]  = '{T_BGE, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
    vecs[3]  = '{T_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    vecs[4]  = '{T_OR,  32'h12340000, 32'h00005678, 32'h12345678, 1'b0};
    vecs[5]  = '{T_XOR, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFF00, 1'b0};
    vecs[6]  = '{T_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
    vecs[7]  = '{T_SRL, 32'h80000000, 32'h00000004, 32'h08000000, 1'b0};
    vecs[8]  = '{T_SLL, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0};
    vecs[9]  = '{T_SRA, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0};
    vecs[10] = '{T_SLL, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0};
    vecs[11] = '{T_BEQ, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
    vecs[12] = '{T_BNE, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0};
    vecs[13] = '{T_SLT, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0};
    vecs[14] = '{T_SLT, 32'h00000001, 32'h80000000, 32'h00000000, 1'b0};
    vecs[15] = '{4'b1110, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b0};
    vecs[16] = '{T_SRA, 32'h7FFFFFF0, 32'h00000024, 32'h07FFFFFF, 1'b0};
    vecs[17] = '{T_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
    vecs[18] = '{T_BGE, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    vecs[19] = '{4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0};

    // Reset values, then in_ready once reset is released.
    #3;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_ALUResult", ALUResult, 32'd0);
    checkOutput("reset_BrTaken", 32'(BrTaken), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] table vectors, back-to-back with out_ready=1");
    for (int i = 0; i < 20; i++)
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].br);
    drain();

    $display("[TB] backpressure: ADD held three cycles, then XOR back-to-back");
    out_ready = 1'b0;
    applyStimulus(T_ADD, 32'd3, 32'd4, 32'd7, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(T_XOR, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0);
    drain();

    $display("[TB] in_ready while an SRA by 4 is in flight");
    applyStimulus(T_SRA, 32'h80000000, 32'd4, 32'hF8000000, 1'b0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("sra_in_ready", 32'(in_ready), ITER ? 32'd0 : 32'd1);
    end
    @(posedge clk);
    #1;
    drain();

    $display("[TB] asynchronous reset during SRL by 20");
    out_ready = 1'b0;
    applyStimulus(T_SRL, 32'hFFFF0000, 32'd20, 32'h00000FFF, 1'b0);
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("async_rst_ALUResult", ALUResult, 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(T_SRL, 32'h80000000, 32'd20, 32'h00000800, 1'b0);
    drain();

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 Parameter DATA_WIDTH, default 32, is the operand and result width.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  Operation/SrcA/SrcB are valid this cycle.
REQ-005 in_ready  output  1  block accepts an operation this cycle.
REQ-006 Operation  input  4  ALU operation select from the ALU controller.
REQ-007 SrcA  input  DATA_WIDTH  first operand.
REQ-008 SrcB  input  DATA_WIDTH  second operand; bits [4:0] are the shift amount for shifts.
REQ-009 out_valid  output  1  ALUResult/BrTaken hold a completed result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 ALUResult  output  DATA_WIDTH  registered result.
REQ-012 BrTaken  output  1  registered branch-condition result; 0 for non-branch ops.

Function
REQ-013 Operation encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 SRL, 0110 SLL, 0111 SRA, 1000 BEQ, 1001 BLT, 1010 BGE, 1011 BNE, 1100 SLT; 1101-1111 yield ALUResult 0, BrTaken 0.
REQ-014 Arithmetic SHALL wrap modulo 2^DATA_WIDTH; BLT/BGE/SLT SHALL compare signed; SLT yields 1 or 0 zero-extended.
REQ-015 Branch ops SHALL set ALUResult to 0 and BrTaken to the condition (BEQ equal, BNE not equal, BLT A<B, BGE A>=B).
REQ-016 A transfer occurs on in_valid && in_ready; operands and Operation SHALL be captured on that edge and ignored otherwise.
REQ-017 FSM states IDLE, SHIFT, DONE; IDLE->DONE on accept of a non-iterative op; IDLE->SHIFT on accept of an iterative shift with shamt != 0; IDLE->DONE for shamt == 0 (result = SrcA).
REQ-018 SHIFT SHALL shift one bit position per cycle, decrementing a 5-bit counter; SHIFT->DONE on the cycle the counter reaches 0.
REQ-019 out_valid SHALL be 1 exactly in DONE; ALUResult/BrTaken SHALL stay stable while out_valid && !out_ready.
REQ-020 DONE->IDLE on out_ready && !in_valid; DONE accepts a new op in the same cycle when out_ready && in_valid (back-to-back).
REQ-021 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready); in_ready SHALL be 0 in SHIFT.
REQ-022 Latency: non-iterative ops SHALL assert out_valid 1 cycle after accept; iterative shift SHALL assert out_valid shamt+1 cycles after accept (1 when shamt = 0).
REQ-023 SRA SHALL replicate SrcA[DATA_WIDTH-1] on every step; SRL/SLL SHALL fill zeros.

Reset
REQ-024 On reset assertion, state SHALL go to IDLE immediately, regardless of clock, including mid-shift; the partial result is discarded.
REQ-025 Reset values: out_valid 0, ALUResult 0, BrTaken 0, shift counter 0; in_ready SHALL be 1 once reset deasserts.

Configuration
REQ-026 Macro ALU_ITER_SHIFT_EN defined: SRL/SLL/SRA SHALL use the iterative SHIFT state per REQ-018/022.
REQ-027 Macro ALU_ITER_SHIFT_EN undefined: shifts SHALL use a single-cycle barrel shifter, SHIFT state SHALL be absent, all ops SHALL have 1-cycle latency.

Structure
REQ-028 A shared package alu_pkg SHALL hold the 4-bit Operation constants of REQ-013 and the FSM state enum; the ALU controller SHALL import the same constants.
REQ-029 One sub-module alu_shifter SHALL contain the shift datapath (iterative or barrel per ALU_ITER_SHIFT_EN); compare/logic/add remain in alu_exec.

Verification
REQ-030 ADD SrcA=0x7FFFFFFF, SrcB=1, out_ready=1 -> out_valid 1 cycle later, ALUResult 0x80000000, BrTaken 0.
REQ-031 BLT SrcA=0xFFFFFFFF, SrcB=1 -> BrTaken 1, ALUResult 0; BGE same operands -> BrTaken 0.
REQ-032 With ALU_ITER_SHIFT_EN: SRA SrcA=0x80000000, SrcB=4 -> in_ready 0 for 4 cycles, out_valid after 5 cycles, ALUResult 0xF8000000; SLL SrcB=0 -> 1 cycle, ALUResult = SrcA.
REQ-033 Backpressure: ADD 3+4 with out_ready=0 for 3 cycles -> ALUResult 7 held, in_ready 0; out_ready=1 with in_valid XOR 0xF0^0x0F -> next cycle ALUResult 0xFF.
REQ-034 Reset asserted asynchronously during SRL SrcB=20 -> out_valid 0 and state IDLE before next clock edge; first op after reset completes normally.
REQ-035 Operation 1110, any operands -> ALUResult 0, BrTaken 0, 1-cycle latency.
